csr_latch_ctrl: RTL and testbench

Write controller for a bank of gated SR latches. Two requesters share the bank. The controller sequences each write as a clean set-up / gate / hold pulse on the latch C, S and R lines. It never drives S=R=1 and never changes S/R while any C is high, so race-through ("空翻") during the gate window cannot occur. It sits between the lab's control logic and the CSR latch bank, and reads back Q to confirm every write.

---
 rtl/csr_latch_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/csr_latch_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_csr_latch_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_latch_pkg.sv
// csr_latch_pkg: shared definitions for the CSR latch write controller.
//   OP_SET / OP_RST : legal operation encodings (bit0 drives S, bit1 drives R)
//   state_e         : write sequencer states
//   aw_of()         : index width for an n-entry table (minimum 1 bit)
package csr_latch_pkg;

    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_RST = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_VERIFY
    } state_e;

    function automatic int aw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : pending requests
//   cap        : capture strobe; the pointer records the current winner
//   gnt[1:0]   : one-hot grant (combinational), zero when nothing requests
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       cap,
    output logic [1:0] gnt
);

    // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie.
    // Resetting to 1 makes req0 the favourite after reset.
    logic last_q, last_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    end

    always_comb begin
        last_d = last_q;
        if (cap && (req != 2'b00)) last_d = gnt[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/csr_latch_ctrl.sv
// csr_latch_ctrl: write sequencer for a bank of gated SR latches shared by
// two requesters. Each write is a set-up / gate / hold pulse, then a
// read-back of Q. S/R never change on the same edge as C, and S=R=1 is
// never driven, so the latch cannot race through while gated.
//   clk, rst_n        : clock, async active-low reset
//   req*/op*/addr*    : requester 0/1 write requests (op 01 = set, 10 = reset)
//   ack0/ack1         : one-cycle completion pulse to the granted requester
//   err               : with ack; illegal op, bad address or read-back mismatch
//   busy              : capture through ack cycle
//   lat_C/lat_S/lat_R : registered latch gate / set / reset lines
//   lat_Q             : latch outputs for read-back
module csr_latch_ctrl
    import csr_latch_pkg::*;
#(
    parameter  int N_LATCH   = 8,
    parameter  int SETUP_CYC = 1,
    parameter  int PULSE_CYC = 1,
    parameter  int HOLD_CYC  = 1,
    localparam int AW        = aw_of(N_LATCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic [1:0]         op0,
    input  logic [AW-1:0]      addr0,
    input  logic               req1,
    input  logic [1:0]         op1,
    input  logic [AW-1:0]      addr1,
    output logic               ack0,
    output logic               ack1,
    output logic               err,
    output logic               busy,
    output logic [N_LATCH-1:0] lat_C,
    output logic               lat_S,
    output logic               lat_R,
    input  logic [N_LATCH-1:0] lat_Q
);

    localparam int MAXC = (SETUP_CYC > PULSE_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CW = aw_of(MAXC);
    // Counter is loaded with phase length - 1 and the phase ends at zero.
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 who_q, who_d;     // 1: requester 1 owns the transaction
    logic                 set_q, set_d;     // expected read-back value
    logic                 cerr_q, cerr_d;   // capture-time error
    logic [AW-1:0]        addr_q, addr_d;
    logic [N_LATCH-1:0]   lat_C_q, lat_C_d;
    logic                 lat_S_q, lat_S_d;
    logic                 lat_R_q, lat_R_d;

    logic [1:0]           gnt;
    logic                 cap;
    logic [1:0]           w_op;
    logic [AW-1:0]        w_addr;
    logic                 w_legal;
    logic [N_LATCH-1:0]   sel;
    logic                 rb_bit;

    assign cap = (state_q == ST_IDLE) && (req0 || req1);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1, req0}),
        .cap   (cap),
        .gnt   (gnt)
    );

    assign w_op    = gnt[0] ? op0 : op1;
    assign w_addr  = gnt[0] ? addr0 : addr1;
    assign w_legal = ((w_op == OP_SET) || (w_op == OP_RST)) && (int'(w_addr) < N_LATCH);

    // One-hot decode of the captured address; all-zero when out of range.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_LATCH; i++) sel[i] = (int'(addr_q) == i);
    end
    assign rb_bit = |(lat_Q & sel);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            who_q   <= 1'b0;
            set_q   <= 1'b0;
            cerr_q  <= 1'b0;
            addr_q  <= '0;
            lat_C_q <= '0;
            lat_S_q <= 1'b0;
            lat_R_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            who_q   <= who_d;
            set_q   <= set_d;
            cerr_q  <= cerr_d;
            addr_q  <= addr_d;
            lat_C_q <= lat_C_d;
            lat_S_q <= lat_S_d;
            lat_R_q <= lat_R_d;
        end
    end

    // Next-state and registered latch-line values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        who_d   = who_q;
        set_d   = set_q;
        cerr_d  = cerr_q;
        addr_d  = addr_q;
        lat_C_d = lat_C_q;
        lat_S_d = lat_S_q;
        lat_R_d = lat_R_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cap) begin
                    who_d  = gnt[1];
                    addr_d = w_addr;
                    set_d  = (w_op == OP_SET);
                    if (w_legal) begin
                        // S/R rise at the capture edge; C follows SETUP_CYC later.
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                        cerr_d  = 1'b0;
                        lat_S_d = w_op[0];
                        lat_R_d = w_op[1];
                    end else begin
                        state_d = ST_VERIFY;
                        cerr_d  = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LD;
                    lat_C_d = sel;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    lat_C_d = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_VERIFY;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_VERIFY: begin
                state_d = ST_IDLE;
                lat_S_d = 1'b0;
                lat_R_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                lat_C_d = '0;
                lat_S_d = 1'b0;
                lat_R_d = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != ST_IDLE);
        ack0 = (state_q == ST_VERIFY) && !who_q;
        ack1 = (state_q == ST_VERIFY) && who_q;
        err  = (state_q == ST_VERIFY) && (cerr_q || (rb_bit != set_q));
    end

    assign lat_C = lat_C_q;
    assign lat_S = lat_S_q;
    assign lat_R = lat_R_q;

endmodule

// File: tb/tb_csr_latch_ctrl.sv
module tb_csr_latch_ctrl;
    import csr_latch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-latch instance
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] op0 = 2'b00, op1 = 2'b00;
    logic [2:0] addr0 = 3'd0, addr1 = 3'd0;
    logic       ack0, ack1, err, busy, lat_S, lat_R;
    logic [7:0] lat_C, lat_Q;
    logic [7:0] q8 = 8'h00;
    logic [7:0] fmask = 8'h00;
    assign lat_Q = q8 & ~fmask;

    // 6-latch instance
    logic       b_req0 = 1'b0, b_req1 = 1'b0;
    logic [1:0] b_op0 = 2'b00, b_op1 = 2'b00;
    logic [2:0] b_addr0 = 3'd0, b_addr1 = 3'd0;
    logic       b_ack0, b_ack1, b_err, b_busy, b_lat_S, b_lat_R;
    logic [5:0] b_lat_C;
    logic [5:0] q6 = 6'h00;

    csr_latch_ctrl #(.N_LATCH(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .addr0(addr0),
        .req1(req1), .op1(op1), .addr1(addr1),
        .ack0(ack0), .ack1(ack1), .err(err), .busy(busy),
        .lat_C(lat_C), .lat_S(lat_S), .lat_R(lat_R), .lat_Q(lat_Q)
    );

    csr_latch_ctrl #(.N_LATCH(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .op0(b_op0), .addr0(b_addr0),
        .req1(b_req1), .op1(b_op1), .addr1(b_addr1),
        .ack0(b_ack0), .ack1(b_ack1), .err(b_err), .busy(b_busy),
        .lat_C(b_lat_C), .lat_S(b_lat_S), .lat_R(b_lat_R), .lat_Q(q6)
    );

    // Behavioural gated SR latches: transparent while C is high.
    always @(lat_C or lat_S or lat_R)
        for (int i = 0; i < 8; i++)
            if (lat_C[i]) begin
                if (lat_S && !lat_R) q8[i] = 1'b1;
                else if (lat_R && !lat_S) q8[i] = 1'b0;
            end
    always @(b_lat_C or b_lat_S or b_lat_R)
        for (int i = 0; i < 6; i++)
            if (b_lat_C[i]) begin
                if (b_lat_S && !b_lat_R) q6[i] = 1'b1;
                else if (b_lat_R && !b_lat_S) q6[i] = 1'b0;
            end

    int n_tests = 0;
    int n_fail  = 0;
    int last    = 1;          // model: requester granted last (1 => req0 wins a tie)
    logic [7:0] exp_q8 = 8'h00;

    // Observations accumulated by step()
    bit c_multi = 0, sr_both = 0, same_edge = 0, act8 = 0, act6 = 0;
    logic [7:0] pc = 8'h00;
    logic [1:0] psr = 2'b00;

    task automatic step();
        @(posedge clk); #1;
        if ($countones(lat_C) > 1 || $countones(b_lat_C) > 1) c_multi = 1;
        if ((lat_S && lat_R) || (b_lat_S && b_lat_R)) sr_both = 1;
        if ((lat_C != pc) && ({lat_S, lat_R} != psr)) same_edge = 1;
        pc = lat_C; psr = {lat_S, lat_R};
        if (lat_C != 0 || lat_S || lat_R) act8 = 1;
        if (b_lat_C != 0 || b_lat_S || b_lat_R) act6 = 1;
    endtask

    // Steps until an ack appears on the chosen instance; n = cycles taken, -1 on timeout.
    task automatic wait_ack(input bit inst, output int n, output bit a0, output bit a1, output bit e);
        n = -1; a0 = 0; a1 = 0; e = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (inst ? (b_ack0 || b_ack1) : (ack0 || ack1)) begin
                n = k;
                a0 = inst ? b_ack0 : ack0;
                a1 = inst ? b_ack1 : ack1;
                e  = inst ? b_err : err;
                return;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step(); step();
        @(negedge clk); rst_n = 1'b1;
        step();
        last = 1;
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if ({lat_C, lat_S, lat_R, ack0, ack1, err, busy} !== 14'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {lat_C, lat_S, lat_R, ack0, ack1, err, busy});
        end
        n_tests++;
        if ({b_lat_C, b_lat_S, b_lat_R, b_ack0, b_ack1, b_err, b_busy} !== 12'h0) begin
            n_fail++; $display("FAIL reset_outputs6: got %h expected 0", {b_lat_C, b_lat_S, b_lat_R, b_ack0, b_ack1, b_err, b_busy});
        end
        @(negedge clk); rst_n = 1'b1;
        step();
        n_tests++;
        if ({busy, ack0, ack1, lat_C, lat_S, lat_R} !== 13'h0) begin
            n_fail++; $display("FAIL idle_after_reset: got %h expected 0", {busy, ack0, ack1, lat_C, lat_S, lat_R});
        end
    endtask

    task automatic test_single_set();
        req0 = 1'b1; op0 = OP_SET; addr0 = 3'd3;
        step();
        n_tests++;
        if ({lat_S, lat_R, lat_C, busy} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
            n_fail++; $display("FAIL set_setup: got %h expected %h", {lat_S, lat_R, lat_C, busy}, {1'b1, 1'b0, 8'h00, 1'b1});
        end
        step();
        n_tests++;
        if ({lat_S, lat_R, lat_C} !== {1'b1, 1'b0, 8'h08}) begin
            n_fail++; $display("FAIL set_pulse: got %h expected %h", {lat_S, lat_R, lat_C}, {1'b1, 1'b0, 8'h08});
        end
        step();
        n_tests++;
        if ({lat_S, lat_R, lat_C, ack0} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL set_hold: got %h expected %h", {lat_S, lat_R, lat_C, ack0}, {1'b1, 1'b0, 8'h00, 1'b0});
        end
        step();
        n_tests++;
        if ({ack0, ack1, err, busy, lat_Q[3]} !== 5'b10011) begin
            n_fail++; $display("FAIL set_ack: got %b expected 10011", {ack0, ack1, err, busy, lat_Q[3]});
        end
        req0 = 1'b0; last = 0; exp_q8[3] = 1'b1;
        step();
        n_tests++;
        if ({busy, ack0, lat_S, lat_R} !== 4'b0) begin
            n_fail++; $display("FAIL set_done: got %b expected 0000", {busy, ack0, lat_S, lat_R});
        end
    endtask

    task automatic test_simultaneous();
        int n; bit a0, a1, e;
        apply_reset();
        c_multi = 0;
        for (int t = 0; t < 2; t++) begin
            req0 = 1'b1; op0 = (t == 0) ? OP_SET : OP_RST; addr0 = 3'd0;
            req1 = 1'b1; op1 = (t == 0) ? OP_RST : OP_SET; addr1 = 3'd1;
            wait_ack(1'b0, n, a0, a1, e);
            n_tests++;
            if ({a0, a1, e} !== 3'b100 || n != 4) begin
                n_fail++; $display("FAIL tie%0d_first: got ack0/ack1/err=%b after %0d expected 100 after 4", t, {a0, a1, e}, n);
            end
            req0 = 1'b0; exp_q8[0] = (t == 0);
            wait_ack(1'b0, n, a0, a1, e);
            n_tests++;
            if ({a0, a1, e} !== 3'b010 || n != 5) begin
                n_fail++; $display("FAIL tie%0d_second: got ack0/ack1/err=%b after %0d expected 010 after 5", t, {a0, a1, e}, n);
            end
            req1 = 1'b0; exp_q8[1] = (t == 1); last = 1;
            step();
        end
        n_tests++;
        if (lat_Q !== exp_q8 || c_multi) begin
            n_fail++; $display("FAIL tie_state: got q=%h multiC=%0d expected q=%h multiC=0", lat_Q, c_multi, exp_q8);
        end
    endtask

    task automatic test_illegal();
        int n; bit a0, a1, e;
        act8 = 0;
        req1 = 1'b1; op1 = 2'b11; addr1 = 3'd2;
        wait_ack(1'b0, n, a0, a1, e);
        n_tests++;
        if ({a0, a1, e} !== 3'b011 || n != 1) begin
            n_fail++; $display("FAIL illegal_op: got ack0/ack1/err=%b after %0d expected 011 after 1", {a0, a1, e}, n);
        end
        req1 = 1'b0; last = 1;
        step();
        n_tests++;
        if (act8 !== 1'b0 || lat_Q !== exp_q8) begin
            n_fail++; $display("FAIL illegal_quiet: got activity=%0d q=%h expected 0 q=%h", act8, lat_Q, exp_q8);
        end
    endtask

    task automatic test_bad_addr();
        int n; bit a0, a1, e;
        act6 = 0;
        b_req0 = 1'b1; b_op0 = OP_SET; b_addr0 = 3'd7;
        wait_ack(1'b1, n, a0, a1, e);
        n_tests++;
        if ({a0, a1, e} !== 3'b101 || n != 1) begin
            n_fail++; $display("FAIL bad_addr: got ack0/ack1/err=%b after %0d expected 101 after 1", {a0, a1, e}, n);
        end
        b_req0 = 1'b0;
        step();
        n_tests++;
        if (act6 !== 1'b0) begin
            n_fail++; $display("FAIL bad_addr_quiet: got activity=%0d expected 0", act6);
        end
        b_req0 = 1'b1; b_addr0 = 3'd5;
        wait_ack(1'b1, n, a0, a1, e);
        n_tests++;
        if ({a0, a1, e} !== 3'b100 || n != 4 || q6 !== 6'h20) begin
            n_fail++; $display("FAIL n6_top_latch: got ack/err=%b after %0d q=%h expected 100 after 4 q=20", {a0, a1, e}, n, q6);
        end
        b_req0 = 1'b0;
        step();
    endtask

    task automatic test_mismatch();
        int n; bit a0, a1, e;
        fmask = 8'h20;
        req0 = 1'b1; op0 = OP_SET; addr0 = 3'd5;
        wait_ack(1'b0, n, a0, a1, e);
        n_tests++;
        if ({a0, a1, e} !== 3'b101 || n != 4) begin
            n_fail++; $display("FAIL readback_mismatch: got ack0/ack1/err=%b after %0d expected 101 after 4", {a0, a1, e}, n);
        end
        req0 = 1'b0; last = 0; exp_q8[5] = 1'b1;
        step();
        fmask = 8'h00;
    endtask

    task automatic test_reset_pulse();
        int n; bit a0, a1, e;
        req0 = 1'b1; op0 = OP_SET; addr0 = 3'd6;
        step(); step();
        n_tests++;
        if (lat_C !== 8'h40) begin
            n_fail++; $display("FAIL rst_pre_pulse: got C=%h expected 40", lat_C);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({lat_C, lat_S, lat_R, ack0, ack1, err, busy} !== 14'h0) begin
            n_fail++; $display("FAIL rst_async_drop: got %h expected 0", {lat_C, lat_S, lat_R, ack0, ack1, err, busy});
        end
        req0 = 1'b0;
        // latch was transparent while C was high, so it keeps the set value
        exp_q8[6] = 1'b1;
        step();
        n_tests++;
        if (ack0 !== 1'b0 || lat_Q !== exp_q8) begin
            n_fail++; $display("FAIL rst_no_ack: got ack0=%b q=%h expected 0 q=%h", ack0, lat_Q, exp_q8);
        end
        @(negedge clk); rst_n = 1'b1;
        step();
        last = 1;
        req0 = 1'b1; op0 = OP_RST; addr0 = 3'd6;
        req1 = 1'b1; op1 = OP_SET; addr1 = 3'd2;
        wait_ack(1'b0, n, a0, a1, e);
        n_tests++;
        if ({a0, a1, e} !== 3'b100 || n != 4) begin
            n_fail++; $display("FAIL post_rst_tie: got ack0/ack1/err=%b after %0d expected 100 after 4", {a0, a1, e}, n);
        end
        req0 = 1'b0; exp_q8[6] = 1'b0;
        wait_ack(1'b0, n, a0, a1, e);
        req1 = 1'b0; exp_q8[2] = 1'b1; last = 1;
        step();
        n_tests++;
        if ({a0, a1, e} !== 3'b010 || n != 5 || lat_Q !== exp_q8) begin
            n_fail++; $display("FAIL post_rst_second: got %b after %0d q=%h expected 010 after 5 q=%h", {a0, a1, e}, n, lat_Q, exp_q8);
        end
    endtask

    task automatic test_random();
        int n, mode, first, w, cnt, lat, k;
        bit a0, a1, e, lg;
        logic [1:0] opv [2];
        logic [2:0] adv [2];
        c_multi = 0; sr_both = 0; same_edge = 0;
        for (int r = 0; r < 40; r++) begin
            mode = int'($urandom_range(0, 2));
            for (int j = 0; j < 2; j++) begin
                k = int'($urandom_range(0, 9));
                opv[j] = (k == 0) ? 2'b00 : (k == 1) ? 2'b11 : (k < 6) ? OP_SET : OP_RST;
                adv[j] = 3'($urandom_range(0, 7));
            end
            op0 = opv[0]; addr0 = adv[0]; op1 = opv[1]; addr1 = adv[1];
            req0 = (mode != 1); req1 = (mode != 0);
            first = (mode == 2) ? ((last == 1) ? 0 : 1) : mode;
            cnt = (mode == 2) ? 2 : 1;
            for (int s = 0; s < cnt; s++) begin
                w = (s == 0) ? first : 1 - first;
                lg = (opv[w] == OP_SET) || (opv[w] == OP_RST);
                lat = lg ? 4 : 1;
                if (s == 1) lat = lat + 1;
                wait_ack(1'b0, n, a0, a1, e);
                n_tests++;
                if (n != lat || a0 != (w == 0) || a1 != (w == 1)) begin
                    n_fail++; $display("FAIL rand%0d_grant: got ack0/ack1=%b%b after %0d expected req%0d after %0d", r, a0, a1, n, w, lat);
                end
                n_tests++;
                if (e !== !lg) begin
                    n_fail++; $display("FAIL rand%0d_err: got %b expected %b", r, e, !lg);
                end
                if (w == 0) req0 = 1'b0; else req1 = 1'b0;
                last = w;
                if (lg) exp_q8[adv[w]] = (opv[w] == OP_SET);
            end
            step();
            n_tests++;
            if (lat_Q !== exp_q8) begin
                n_fail++; $display("FAIL rand%0d_latches: got %h expected %h", r, lat_Q, exp_q8);
            end
        end
        n_tests++;
        if ({c_multi, sr_both, same_edge} !== 3'b000) begin
            n_fail++; $display("FAIL line_rules: got multiC/SR/sameEdge=%b expected 000", {c_multi, sr_both, same_edge});
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_simultaneous();
        test_illegal();
        test_bad_addr();
        test_mismatch();
        test_reset_pulse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
